// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional WB operand bypass is enabled with `define ID_EX_WB_BYPASS_EN.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_rs1Data,
    input  logic [DATA_W-1:0] i_rs2Data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [4:0]        i_rd,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_wbWrSig,
    input  logic [4:0]        i_wbWrReg,
    input  logic [DATA_W-1:0] i_wbWrData,
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_rs1Data,
    output logic [DATA_W-1:0] o_rs2Data,
    output logic [DATA_W-1:0] o_imm,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [4:0]        o_rd,
    output logic [CTRL_W-1:0] o_ctrl
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1Data;
        logic [DATA_W-1:0] rs2Data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;

    bundle_t in_bundle;
    bundle_t in_fixed;
    bundle_t out_fixed;
    bundle_t skid_fixed;

    logic accept;
    logic issue;

`ifdef ID_EX_WB_BYPASS_EN
    function automatic bundle_t wb_fix(input bundle_t b, input logic wr,
                                       input logic [4:0] wr_reg,
                                       input logic [DATA_W-1:0] wr_data);
        bundle_t r;
        r = b;
        if (wr && (wr_reg != 5'd0)) begin
            if (wr_reg == b.rs1) r.rs1Data = wr_data;
            if (wr_reg == b.rs2) r.rs2Data = wr_data;
        end
        return r;
    endfunction

    assign in_fixed   = wb_fix(in_bundle, i_wbWrSig, i_wbWrReg, i_wbWrData);
    assign out_fixed  = wb_fix(out_q, i_wbWrSig, i_wbWrReg, i_wbWrData);
    assign skid_fixed = wb_fix(skid_q, i_wbWrSig, i_wbWrReg, i_wbWrData);
`else
    logic unused_wb;
    assign unused_wb  = ^{i_wbWrSig, i_wbWrReg, i_wbWrData};
    assign in_fixed   = in_bundle;
    assign out_fixed  = out_q;
    assign skid_fixed = skid_q;
`endif

    assign in_bundle = '{pc: i_pc, rs1Data: i_rs1Data, rs2Data: i_rs2Data,
                         imm: i_imm, rs1: i_rs1, rs2: i_rs2, rd: i_rd,
                         ctrl: i_ctrl};

    assign o_id_ready = (state_q != S_FULL);
    assign o_ex_valid = (state_q != S_EMPTY);
    assign accept     = i_id_valid & o_id_ready;
    assign issue      = o_ex_valid & i_ex_ready;

    // Held entries are refreshed through the bypass every cycle; in the
    // default build out_fixed/skid_fixed are just the stored values.
    always_comb begin
        state_d = state_q;
        out_d   = out_fixed;
        skid_d  = skid_fixed;
        if (i_flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_d   = in_fixed;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && issue) begin
                        out_d = in_fixed;
                    end else if (accept) begin
                        skid_d  = in_fixed;
                        state_d = S_FULL;
                    end else if (issue) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (issue) begin
                        out_d   = skid_fixed;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_pc      = out_q.pc;
    assign o_rs1Data = out_q.rs1Data;
    assign o_rs2Data = out_q.rs2Data;
    assign o_imm     = out_q.imm;
    assign o_rs1     = out_q.rs1;
    assign o_rs2     = out_q.rs2;
    assign o_rd      = out_q.rd;
    assign o_ctrl    = out_q.ctrl;

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Pipeline register between decode (register-file read, immediate gen, control decode) and execute.
- Captures the decoded instruction bundle with a valid/ready handshake, 1-cycle latency.
- 2-entry skid buffer so o_id_ready is a registered-state signal; synchronous flush for branch/jump redirect.
- Optional WB bypass covers write-at-edge vs async-read staleness.

Parameters:
- DATA_W, 32, width of PC, operand and immediate fields.
- CTRL_W, 16, width of the opaque control bundle passed to EX.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  async active-low reset.
- i_flush  in  1  sync kill of all held and incoming entries.
- i_id_valid  in  1  decode bundle valid.
- o_id_ready  out  1  block can accept a bundle.
- i_pc  in  DATA_W  instruction PC.
- i_rs1Data  in  DATA_W  register-file read port 1 data.
- i_rs2Data  in  DATA_W  register-file read port 2 data.
- i_imm  in  DATA_W  immediate.
- i_rs1  in  5  source register index 1.
- i_rs2  in  5  source register index 2.
- i_rd  in  5  destination register index.
- i_ctrl  in  CTRL_W  control bundle.
- i_wbWrSig  in  1  WB write enable; used only with the macro.
- i_wbWrReg  in  5  WB destination register.
- i_wbWrData  in  DATA_W  WB data.
- o_ex_valid  out  1  EX bundle valid.
- i_ex_ready  in  1  EX accepts the bundle.
- o_pc, o_rs1Data, o_rs2Data, o_imm  out  DATA_W  registered bundle fields.
- o_rs1, o_rs2, o_rd  out  5  registered register indices.
- o_ctrl  out  CTRL_W  registered control bundle.

Behaviour:
- Reset: i_i_reset_n is asynchronous, active-low; clock is i_clk. On reset, state=EMPTY, o_ex_valid=0, all data outputs and skid contents=0, o_id_ready=1.
- Definitions: accept = i_id_valid & o_id_ready; issue = o_ex_valid & i_ex_ready.
- o_id_ready = (state != FULL). Depends on state only, never combinationally on i_ex_ready or i_flush.
- State EMPTY (out invalid, skid empty):
  - accept -> ONE; out register loads the input.
- State ONE (out valid, skid empty):
  - accept & issue -> ONE; out loads the input.
  - accept only -> FULL; skid loads the input.
  - issue only -> EMPTY.
  - neither -> hold.
- State FULL (out valid, skid valid; no accept possible):
  - issue -> ONE; out loads skid.
  - else hold.
- Latency: bundle accepted at edge N is visible on outputs after edge N and issuable in cycle N+1.
- Ordering: strict FIFO; no reordering or duplication.
- While o_ex_valid=1 and i_ex_ready=0, all o_* outputs hold stable.
- i_flush (highest priority): at the next edge, state=EMPTY and o_ex_valid=0. Any input accepted in the flush cycle is discarded. Payload registers need not clear.
- Flush while FULL: both entries dropped; o_id_ready=1 in the following cycle.
- o_ex_valid is 0 in EMPTY and 1 in ONE/FULL.

Optional Feature:
- Macro ID_EX_WB_BYPASS_EN.
- Defined, on capture: when an entry loads from input and i_wbWrSig=1 and i_wbWrReg!=0:
  - i_wbWrReg==i_rs1 -> rs1Data field takes i_wbWrData.
  - i_wbWrReg==i_rs2 -> rs2Data field takes i_wbWrData.
- Defined, while held: every cycle, an out or skid entry whose stored rs1/rs2 matches a valid nonzero WB write updates that field to i_wbWrData.
- Defined, FULL->ONE shift: a skid entry shifting to out in the same cycle as a matching WB write carries the new data.
- Not defined: WB ports are ignored; operand data is exactly as captured.
- x0 is never bypassed.

Test Plan:
- Reset then push pc=0x100, rs1Data=0xAAAA, rd=5 with i_ex_ready=1 -> o_ex_valid=1 one cycle later, o_pc=0x100, o_rd=5; next cycle o_ex_valid=0.
- i_ex_ready=0, push bundles pc=0x10,0x14,0x18 back-to-back -> 0x10,0x14 accepted; o_id_ready=0 from the cycle after 0x14 is accepted; 0x18 held off. Raise i_ex_ready -> EX sees 0x10,0x14,0x18 in order, no gaps.
- FULL state, assert i_flush with i_id_valid=1 pc=0x20 -> next cycle o_ex_valid=0, o_id_ready=1; 0x20 never issued.
- Continuous valid/ready=1 stream of 8 bundles -> 8 issues in 8 consecutive cycles, state never reaches FULL.
- Assert i_reset_n=0 mid-stream while FULL -> o_ex_valid=0 immediately (async), all outputs 0, o_id_ready=1.
- With ID_EX_WB_BYPASS_EN:
  - capture rs1=3, i_rs1Data=0x1, WB writes x3=0x55 same cycle -> o_rs1Data=0x55.
  - WB writes x0=0x77 with rs2=0 -> o_rs2Data unchanged.
  - held entry rs2=7, WB writes x7=0x99 -> o_rs2Data=0x99 next cycle.
